// File: rtl/bin2rns_lut_2_if.sv
// Bus bundle for the binary-to-RNS forward converter: input word, four
// moduli, four weight tables and the four registered residues.
interface bin2rns_lut_2_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MOD_SIZE = 3
);
    localparam int unsigned MOD_W = MOD_SIZE + 1;
    localparam int unsigned LUT_W = MOD_SIZE * WIDTH;

    logic [WIDTH-1:0]    n;
    logic [MOD_W-1:0]    mod_1;
    logic [MOD_W-1:0]    mod_2;
    logic [MOD_W-1:0]    mod_3;
    logic [MOD_W-1:0]    mod_4;
    logic [LUT_W-1:0]    lut_1;
    logic [LUT_W-1:0]    lut_2;
    logic [LUT_W-1:0]    lut_3;
    logic [LUT_W-1:0]    lut_4;
    logic [MOD_SIZE-1:0] out_mod_1;
    logic [MOD_SIZE-1:0] out_mod_2;
    logic [MOD_SIZE-1:0] out_mod_3;
    logic [MOD_SIZE-1:0] out_mod_4;

    // Source of the word, moduli and tables; sink of the residues.
    modport master (
        output n, mod_1, mod_2, mod_3, mod_4, lut_1, lut_2, lut_3, lut_4,
        input  out_mod_1, out_mod_2, out_mod_3, out_mod_4
    );

    // Converter side.
    modport slave (
        input  n, mod_1, mod_2, mod_3, mod_4, lut_1, lut_2, lut_3, lut_4,
        output out_mod_1, out_mod_2, out_mod_3, out_mod_4
    );
endinterface

// File: rtl/bin2rns_lut_2.sv
// Binary-to-RNS forward converter: four independent channels, each summing
// the table weights of the set bits of n and reducing modulo its runtime
// modulus. One registered result per clock, latency one cycle.
module bin2rns_lut_2 #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MOD_SIZE = 3
) (
    input  logic            clk,
    input  logic            reset,
    bin2rns_lut_2_if.slave  bus
);
    localparam int unsigned N_MOD   = 4;
    localparam int unsigned MOD_W   = MOD_SIZE + 1;
    localparam int unsigned LUT_W   = MOD_SIZE * WIDTH;
    localparam int unsigned MOD_MAX = 1 << MOD_SIZE;
    localparam int unsigned SUM_MAX = WIDTH * (MOD_MAX - 1);
    localparam int unsigned SUM_W   = $clog2(SUM_MAX + 1);
    // Remainder before a compare/subtract step is < 2*m <= 2*MOD_MAX.
    localparam int unsigned REM_W   = MOD_SIZE + 2;

    logic [MOD_W-1:0]    mod_c     [N_MOD];
    logic [LUT_W-1:0]    lut_c     [N_MOD];
    logic [MOD_SIZE-1:0] out_mod_d [N_MOD];
    logic [MOD_SIZE-1:0] out_mod_q [N_MOD];

    // Sum of the weights of all set bits; the MSB slice already carries the
    // negative two's-complement weight, so signed inputs need nothing extra.
    function automatic logic [SUM_W-1:0] weight_sum(
        input logic [WIDTH-1:0] v,
        input logic [LUT_W-1:0] lut
    );
        logic [SUM_W-1:0] s;
        s = '0;
        for (int unsigned j = 0; j < WIDTH; j++) begin
            if (v[j]) begin
                s = s + SUM_W'(lut[MOD_SIZE*j +: MOD_SIZE]);
            end
        end
        return s;
    endfunction

    // Restoring remainder of s by m; exact for any table entry value, so
    // entries that are not pre-reduced below m still give the right residue.
    function automatic logic [MOD_SIZE-1:0] reduce(
        input logic [SUM_W-1:0] s,
        input logic [MOD_W-1:0] m
    );
        logic [REM_W-1:0] r;
        logic [REM_W-1:0] m_ext;
        r     = '0;
        m_ext = REM_W'(m);
        for (int i = int'(SUM_W) - 1; i >= 0; i--) begin
            r = {r[REM_W-2:0], s[i]};
            if (r >= m_ext) begin
                r = r - m_ext;
            end
        end
        return MOD_SIZE'(r);
    endfunction

    // A modulus outside [2, 2**MOD_SIZE] forces that channel to zero.
    function automatic logic mod_legal(input logic [MOD_W-1:0] m);
        return (m >= MOD_W'(2)) && (m <= MOD_W'(MOD_MAX));
    endfunction

    // Gather the per-channel bus fields into arrays.
    always_comb begin
        mod_c[0] = bus.mod_1;
        mod_c[1] = bus.mod_2;
        mod_c[2] = bus.mod_3;
        mod_c[3] = bus.mod_4;
        lut_c[0] = bus.lut_1;
        lut_c[1] = bus.lut_2;
        lut_c[2] = bus.lut_3;
        lut_c[3] = bus.lut_4;
    end

    // Next residue of every channel.
    always_comb begin
        for (int k = 0; k < int'(N_MOD); k++) begin
            out_mod_d[k] = '0;
            if (mod_legal(mod_c[k])) begin
                out_mod_d[k] = reduce(weight_sum(bus.n, lut_c[k]), mod_c[k]);
            end
        end
    end

    // Result registers, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < int'(N_MOD); k++) begin
                out_mod_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(N_MOD); k++) begin
                out_mod_q[k] <= out_mod_d[k];
            end
        end
    end

    assign bus.out_mod_1 = out_mod_q[0];
    assign bus.out_mod_2 = out_mod_q[1];
    assign bus.out_mod_3 = out_mod_q[2];
    assign bus.out_mod_4 = out_mod_q[3];

endmodule

// File: tb/tb_bin2rns_lut_2.sv
// Self-checking bench for bin2rns_lut_2: fixed vectors, full sweep of the
// reference dynamic range, randomized moduli/tables and async reset cases.
module tb_bin2rns_lut_2;
    localparam int WIDTH    = 32;
    localparam int MOD_SIZE = 3;
    localparam int LUT_W    = MOD_SIZE * WIDTH;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   cur_m [4];

    bin2rns_lut_2_if #(.WIDTH(WIDTH), .MOD_SIZE(MOD_SIZE)) bus ();

    bin2rns_lut_2 #(.WIDTH(WIDTH), .MOD_SIZE(MOD_SIZE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Residue of the signed value n modulo m; illegal moduli give 0.
    function automatic int model(input logic [31:0] nv, input int m);
        longint v;
        longint r;
        if (m < 2 || m > 8) return 0;
        v = longint'($signed(nv));
        r = v % longint'(m);
        if (r < 0) r = r + longint'(m);
        return int'(r);
    endfunction

    // Weight table from first principles; alt adds m to some entries when it
    // still fits in 3 bits, giving a congruent but unreduced table.
    function automatic logic [LUT_W-1:0] make_lut(input int m, input bit alt);
        logic [LUT_W-1:0] t;
        longint w;
        t = '0;
        if (m < 2) begin
            t = {$urandom, $urandom, $urandom};
            return t;
        end
        for (int j = 0; j < WIDTH; j++) begin
            if (j == WIDTH - 1) w = -(longint'(1) <<< (WIDTH - 1));
            else                w = longint'(1) <<< j;
            w = w % longint'(m);
            if (w < 0) w = w + longint'(m);
            if (alt && (w + longint'(m) <= 7) && ($urandom_range(1) == 1)) w = w + longint'(m);
            t[MOD_SIZE*j +: MOD_SIZE] = 3'(w);
        end
        return t;
    endfunction

    task automatic drive(input logic [31:0] nv, input bit alt);
        bus.n     = nv;
        bus.mod_1 = 4'(cur_m[0]);
        bus.mod_2 = 4'(cur_m[1]);
        bus.mod_3 = 4'(cur_m[2]);
        bus.mod_4 = 4'(cur_m[3]);
        bus.lut_1 = make_lut(cur_m[0], alt);
        bus.lut_2 = make_lut(cur_m[1], alt);
        bus.lut_3 = make_lut(cur_m[2], alt);
        bus.lut_4 = make_lut(cur_m[3], alt);
    endtask

    function automatic int get_out(input int k);
        case (k)
            0:       return int'(bus.out_mod_1);
            1:       return int'(bus.out_mod_2);
            2:       return int'(bus.out_mod_3);
            default: return int'(bus.out_mod_4);
        endcase
    endfunction

    task automatic set_ref_moduli();
        cur_m[0] = 8; cur_m[1] = 7; cur_m[2] = 5; cur_m[3] = 3;
    endtask

    task automatic test_reset();
        int g;
        set_ref_moduli();
        reset = 1'b0;
        drive($urandom, 1'b0);
        #1;
        for (int k = 0; k < 4; k++) begin
            g = get_out(k);
            total++;
            if (g !== 0) begin
                bad++;
                $display("FAIL reset_async ch%0d got=%0d want=0", k + 1, g);
            end
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive(32'd0, 1'b0);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            g = get_out(k);
            total++;
            if (g !== 0) begin
                bad++;
                $display("FAIL reset_release_n0 ch%0d got=%0d want=0", k + 1, g);
            end
        end
    endtask

    task automatic test_vectors();
        logic [31:0] vn  [5];
        int          exp [5][4];
        int          g;
        vn[0] = 32'd1;         exp[0] = '{1, 1, 1, 1};
        vn[1] = 32'd100;       exp[1] = '{4, 2, 0, 1};
        vn[2] = 32'd419;       exp[2] = '{3, 6, 4, 2};
        vn[3] = 32'hFFFF_FFFF; exp[3] = '{7, 6, 4, 2};
        vn[4] = -32'sd420;     exp[4] = '{4, 0, 0, 0};
        set_ref_moduli();
        for (int i = 0; i < 5; i++) begin
            drive(vn[i], 1'b0);
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) begin
                g = get_out(k);
                total++;
                if (g !== exp[i][k]) begin
                    bad++;
                    $display("FAIL vector n=%0d ch%0d got=%0d want=%0d",
                             $signed(vn[i]), k + 1, g, exp[i][k]);
                end
            end
        end
    endtask

    task automatic test_sweep();
        int g;
        int e;
        set_ref_moduli();
        for (int v = -420; v <= 419; v++) begin
            drive(32'(v), 1'b0);
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) begin
                g = get_out(k);
                e = model(32'(v), cur_m[k]);
                total++;
                if (g !== e) begin
                    bad++;
                    $display("FAIL sweep n=%0d ch%0d got=%0d want=%0d", v, k + 1, g, e);
                end
            end
        end
    endtask

    task automatic test_illegal_mod();
        int g;
        int exp [4];
        set_ref_moduli();
        cur_m[1] = 0;
        exp = '{4, 0, 0, 1};
        drive(32'd100, 1'b0);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            g = get_out(k);
            total++;
            if (g !== exp[k]) begin
                bad++;
                $display("FAIL illegal_mod2 ch%0d got=%0d want=%0d", k + 1, g, exp[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] nv;
        int g;
        int e;
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 4; k++) cur_m[k] = int'($urandom_range(15));
            nv = (i % 2 == 0) ? $urandom : 32'($signed($urandom_range(2000)) - 1000);
            drive(nv, 1'b1);
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) begin
                g = get_out(k);
                e = model(nv, cur_m[k]);
                total++;
                if (g !== e) begin
                    bad++;
                    $display("FAIL random n=%0d m=%0d ch%0d got=%0d want=%0d",
                             $signed(nv), cur_m[k], k + 1, g, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int g;
        int e;
        set_ref_moduli();
        for (int v = -50; v < -40; v++) begin
            drive(32'(v), 1'b0);
            @(posedge clk); #1;
        end
        #2;
        reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            g = get_out(k);
            total++;
            if (g !== 0) begin
                bad++;
                $display("FAIL reset_mid_immediate ch%0d got=%0d want=0", k + 1, g);
            end
        end
        #13;
        for (int k = 0; k < 4; k++) begin
            g = get_out(k);
            total++;
            if (g !== 0) begin
                bad++;
                $display("FAIL reset_mid_held ch%0d got=%0d want=0", k + 1, g);
            end
        end
        #1;
        reset = 1'b1;
        drive(32'd37, 1'b0);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            g = get_out(k);
            e = model(32'd37, cur_m[k]);
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL reset_mid_resume ch%0d got=%0d want=%0d", k + 1, g, e);
            end
        end
        for (int v = -40; v < -30; v++) begin
            drive(32'(v), 1'b0);
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) begin
                g = get_out(k);
                e = model(32'(v), cur_m[k]);
                total++;
                if (g !== e) begin
                    bad++;
                    $display("FAIL reset_mid_stream n=%0d ch%0d got=%0d want=%0d", v, k + 1, g, e);
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_vectors();
        test_sweep();
        test_illegal_mod();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
